// File: rtl/game_pkg.sv
// game_pkg: state encoding, LFSR constants and default countdown for game_ctrl.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bit i of the mask is tap i+1: taps 16/14/13/11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEFAULT_START_SEC = 300;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_timer.sv
// bcd_timer: BCD mm:ss countdown with synchronous load of START_SEC and
// a single-second decrement that holds at 0:00.
module bcd_timer
    import game_pkg::*;
#(
    parameter int START_SEC = DEFAULT_START_SEC
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] min,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic       zero
);

    localparam logic [3:0] LOAD_MIN   = 4'(START_SEC / 60);
    localparam logic [2:0] LOAD_SEC_T = 3'((START_SEC % 60) / 10);
    localparam logic [3:0] LOAD_SEC_U = 4'(START_SEC % 10);

    assign zero = (min == 4'd0) && (sec_t == 3'd0) && (sec_u == 4'd0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            min   <= LOAD_MIN;
            sec_t <= LOAD_SEC_T;
            sec_u <= LOAD_SEC_U;
        end else if (load) begin
            min   <= LOAD_MIN;
            sec_t <= LOAD_SEC_T;
            sec_u <= LOAD_SEC_U;
        end else if (dec && !zero) begin
            if (sec_u != 4'd0) begin
                sec_u <= sec_u - 4'd1;
            end else begin
                sec_u <= 4'd9;
                if (sec_t != 3'd0) begin
                    sec_t <= sec_t - 3'd1;
                end else begin
                    sec_t <= 3'd5;
                    min   <= min - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: bomb-level countdown, strike accounting and arm/defuse/explode FSM.
// Define GAME_CTRL_SPEEDUP_EN to shorten the second period as strikes accrue.
//
// state       | meaning
// ST_IDLE     | timer held at START_SEC, waiting for start
// ST_ARMED    | countdown running, strikes counted
// ST_DEFUSED  | puzzle solved, everything frozen until start
// ST_EXPLODED | strikes or time ran out, buzzer on until start
module game_ctrl
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int START_SEC     = DEFAULT_START_SEC,
    parameter int MAX_STRIKES   = 3,
    parameter int BEEP_MS       = 100
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start_btn,
    input  logic        wrong_tgl,
    input  logic        module_done,
    output logic [11:0] oseed,
    output logic        mod,
    output logic [1:0]  wrong_time,
    output logic [1:0]  strikes,
    output logic [3:0]  time_min,
    output logic [2:0]  time_sec_t,
    output logic [3:0]  time_sec_u,
    output logic [1:0]  state,
    output logic        beep
);

    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam int BW = $clog2(BEEP_MS + 1);

    state_t          state_q, state_nxt;
    logic [1:0]      start_sync, wrong_sync;
    logic            start_hist, wrong_hist;
    logic            start_ev, strike_ev;
    logic [15:0]     lfsr;
    logic [PW-1:0]   presc, period_q, period_nxt;
    logic [BW-1:0]   beep_cnt;
    logic [1:0]      strikes_d;
    logic            tick, strike_hit, detonate, timeout, time_zero;
    logic            tmr_load, tmr_dec;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            start_sync <= '0;
            start_hist <= 1'b0;
            wrong_sync <= '0;
            wrong_hist <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            start_sync <= {start_sync[0], start_btn};
            start_hist <= start_sync[1];
            wrong_sync <= {wrong_sync[0], wrong_tgl};
            wrong_hist <= wrong_sync[1];
            lfsr       <= lfsr_step(lfsr);
        end
    end

    assign start_ev  = start_sync[1] & ~start_hist;
    assign strike_ev = wrong_sync[1] ^ wrong_hist;

`ifdef GAME_CTRL_SPEEDUP_EN
    always_comb begin
        case (strikes)
            2'd0:    period_nxt = PW'(TICKS_PER_SEC);
            2'd1:    period_nxt = PW'((TICKS_PER_SEC * 3) / 4);
            default: period_nxt = PW'(TICKS_PER_SEC / 2);
        endcase
    end
`else
    assign period_nxt = PW'(TICKS_PER_SEC);
`endif

    assign tick       = (state_q == ST_ARMED) && (presc == period_q - PW'(1));
    assign strike_hit = (state_q == ST_ARMED) && strike_ev && !module_done;
    assign detonate   = strike_hit && (int'(strikes) + 1 == MAX_STRIKES);
    assign timeout    = tick && (time_min == 4'd0) && (time_sec_t == 3'd0)
                        && (time_sec_u == 4'd1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (start_ev) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (module_done)             state_nxt = ST_DEFUSED;
                else if (detonate || timeout) state_nxt = ST_EXPLODED;
            end
            default:  if (start_ev) state_nxt = ST_IDLE;
        endcase
    end

    // Period is re-sampled only at a wrap so a running second is never cut short.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc    <= '0;
            period_q <= PW'(TICKS_PER_SEC);
        end else if (state_q == ST_IDLE) begin
            presc    <= '0;
            period_q <= PW'(TICKS_PER_SEC);
        end else if (state_q == ST_ARMED) begin
            if (tick) begin
                presc    <= '0;
                period_q <= period_nxt;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_comb begin
        strikes_d = strikes;
        if (state_nxt == ST_IDLE) strikes_d = 2'd0;
        else if (strike_hit)      strikes_d = strikes + 2'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            strikes    <= 2'd0;
            wrong_time <= 2'd0;
            oseed      <= 12'd0;
            mod        <= 1'b0;
        end else begin
            strikes    <= strikes_d;
            wrong_time <= (strikes_d >= 2'd2) ? 2'd2 : strikes_d;
            if (state_q == ST_IDLE && start_ev) begin
                oseed <= lfsr[11:0];
                mod   <= lfsr[12];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state_nxt == ST_EXPLODED) begin
            beep     <= 1'b1;
            beep_cnt <= '0;
        end else if (state_nxt == ST_ARMED) begin
            if (tick) begin
                beep     <= 1'b1;
                beep_cnt <= BW'(BEEP_MS - 1);
            end else if (beep_cnt != '0) begin
                beep     <= 1'b1;
                beep_cnt <= beep_cnt - BW'(1);
            end else begin
                beep <= 1'b0;
            end
        end else begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end
    end

    assign tmr_load = (state_nxt == ST_IDLE);
    assign tmr_dec  = tick && !module_done;

    bcd_timer #(.START_SEC(START_SEC)) u_timer (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .min   (time_min),
        .sec_t (time_sec_t),
        .sec_u (time_sec_u),
        .zero  (time_zero)
    );

    assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scenarios for game_ctrl; a second instance runs a 2-second game.
module tb_game_ctrl;

    logic        Clk, rst_n, start_btn, wrong_tgl, module_done, start2;
    logic [11:0] oseed, oseed2;
    logic        mod, mod2, beep, beep2;
    logic [1:0]  wrong_time, strikes, state, wrong_time2, strikes2, state2;
    logic [3:0]  time_min, time_sec_u, time_min2, time_sec_u2;
    logic [2:0]  time_sec_t, time_sec_t2;
    logic [10:0] tm, tm2;
    logic [15:0] lfsr_m, lfsr_prev;
    logic [11:0] seed_prev;
    int          total, bad;

`ifdef GAME_CTRL_SPEEDUP_EN
    localparam int EXP_PERIOD = 500;
`else
    localparam int EXP_PERIOD = 1000;
`endif

    game_ctrl dut (
        .Clk(Clk), .Rst_n(rst_n), .start_btn(start_btn), .wrong_tgl(wrong_tgl),
        .module_done(module_done), .oseed(oseed), .mod(mod), .wrong_time(wrong_time),
        .strikes(strikes), .time_min(time_min), .time_sec_t(time_sec_t),
        .time_sec_u(time_sec_u), .state(state), .beep(beep)
    );

    game_ctrl #(.START_SEC(2)) dut2 (
        .Clk(Clk), .Rst_n(rst_n), .start_btn(start2), .wrong_tgl(1'b0),
        .module_done(1'b0), .oseed(oseed2), .mod(mod2), .wrong_time(wrong_time2),
        .strikes(strikes2), .time_min(time_min2), .time_sec_t(time_sec_t2),
        .time_sec_u(time_sec_u2), .state(state2), .beep(beep2)
    );

    assign tm  = {time_min, time_sec_t, time_sec_u};
    assign tm2 = {time_min2, time_sec_t2, time_sec_u2};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference LFSR; lfsr_prev holds the value the DUT sampled at the last edge.
    always @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'h0000;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_btn = 1'b0; wrong_tgl = 1'b0; module_done = 1'b0; start2 = 1'b0;
        step(2);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (strikes !== 2'd0 || wrong_time !== 2'd0) begin bad++; $display("FAIL reset_strikes got=%0d/%0d exp=0/0", strikes, wrong_time); end
        total++; if (beep !== 1'b0) begin bad++; $display("FAIL reset_beep got=%0b exp=0", beep); end
        total++; if (oseed !== 12'd0 || mod !== 1'b0) begin bad++; $display("FAIL reset_seed got=%0h/%0b exp=0/0", oseed, mod); end
        total++; if (tm !== {4'd5, 3'd0, 4'd0}) begin bad++; $display("FAIL reset_time got=%0h exp=%0h", tm, {4'd5, 3'd0, 4'd0}); end
        total++; if (tm2 !== {4'd0, 3'd0, 4'd2}) begin bad++; $display("FAIL reset_time2 got=%0h exp=%0h", tm2, {4'd0, 3'd0, 4'd2}); end
        rst_n = 1'b1;
    endtask

    task automatic test_start_and_tick;
        start_btn = 1'b1;
        step(2);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL start_latency got=%0d exp=0", state); end
        step(1);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL start_armed got=%0d exp=1", state); end
        total++; if (oseed !== lfsr_prev[11:0] || mod !== lfsr_prev[12]) begin
            bad++; $display("FAIL start_seed got=%0h/%0b exp=%0h/%0b", oseed, mod, lfsr_prev[11:0], lfsr_prev[12]);
        end
        seed_prev = lfsr_prev[11:0];
        start_btn = 1'b0;
        step(999);
        total++; if (tm !== {4'd5, 3'd0, 4'd0} || beep !== 1'b0) begin bad++; $display("FAIL pre_tick got=%0h/%0b exp=500/0", tm, beep); end
        step(1);
        total++; if (tm !== {4'd4, 3'd5, 4'd9}) begin bad++; $display("FAIL first_tick got=%0h exp=%0h", tm, {4'd4, 3'd5, 4'd9}); end
        total++; if (beep !== 1'b1) begin bad++; $display("FAIL beep_start got=%0b exp=1", beep); end
        step(99);
        total++; if (beep !== 1'b1) begin bad++; $display("FAIL beep_hold got=%0b exp=1", beep); end
        step(1);
        total++; if (beep !== 1'b0) begin bad++; $display("FAIL beep_end got=%0b exp=0", beep); end
    endtask

    task automatic test_strikes;
        for (int i = 1; i <= 3; i++) begin
            wrong_tgl = ~wrong_tgl;
            step(3);
            total++; if (strikes !== 2'(i)) begin bad++; $display("FAIL strike_count%0d got=%0d exp=%0d", i, strikes, i); end
            total++; if (wrong_time !== ((i >= 2) ? 2'd2 : 2'(i))) begin bad++; $display("FAIL wrong_time%0d got=%0d exp=%0d", i, wrong_time, (i >= 2) ? 2 : i); end
            if (i < 3) begin
                total++; if (state !== 2'd1) begin bad++; $display("FAIL strike_armed%0d got=%0d exp=1", i, state); end
                step(297);
            end
        end
        total++; if (state !== 2'd3 || beep !== 1'b1) begin bad++; $display("FAIL exploded got=%0d/%0b exp=3/1", state, beep); end
        step(1500);
        total++; if (tm !== {4'd4, 3'd5, 4'd9} || beep !== 1'b1) begin bad++; $display("FAIL explode_frozen got=%0h/%0b exp=459/1", tm, beep); end
        wrong_tgl = ~wrong_tgl;
        step(4);
        total++; if (strikes !== 2'd3) begin bad++; $display("FAIL explode_strike_ignored got=%0d exp=3", strikes); end
    endtask

    task automatic test_restart_from_explode;
        start_btn = 1'b1;
        step(3);
        total++; if (state !== 2'd0 || beep !== 1'b0) begin bad++; $display("FAIL rearm_idle got=%0d/%0b exp=0/0", state, beep); end
        total++; if (tm !== {4'd5, 3'd0, 4'd0} || strikes !== 2'd0 || wrong_time !== 2'd0) begin
            bad++; $display("FAIL rearm_reload got=%0h/%0d/%0d exp=500/0/0", tm, strikes, wrong_time);
        end
        start_btn = 1'b0;
        step(4);
    endtask

    task automatic test_speedup;
        logic [10:0] last;
        int n;
        start_btn = 1'b1;
        step(3);
        total++; if (state !== 2'd1 || oseed !== lfsr_prev[11:0]) begin bad++; $display("FAIL game2_arm got=%0d/%0h exp=1/%0h", state, oseed, lfsr_prev[11:0]); end
        start_btn = 1'b0;
        wrong_tgl = ~wrong_tgl;
        step(300);
        wrong_tgl = ~wrong_tgl;
        step(3);
        total++; if (strikes !== 2'd2) begin bad++; $display("FAIL game2_strikes got=%0d exp=2", strikes); end
        last = tm; n = 0;
        while (tm === last && n < 1200) begin step(1); n++; end
        total++; if (tm !== {4'd4, 3'd5, 4'd9}) begin bad++; $display("FAIL game2_tick1 got=%0h exp=459 after %0d cycles", tm, n); end
        last = tm; n = 0;
        while (tm === last && n < 1200) begin step(1); n++; end
        total++; if (n != EXP_PERIOD) begin bad++; $display("FAIL tick_period got=%0d exp=%0d", n, EXP_PERIOD); end
        total++; if (tm !== {4'd4, 3'd5, 4'd8}) begin bad++; $display("FAIL game2_tick2 got=%0h exp=458", tm); end
    endtask

    task automatic test_defuse_same_cycle;
        wrong_tgl = ~wrong_tgl;
        step(2);
        module_done = 1'b1;
        step(1);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL defuse_priority got=%0d exp=2", state); end
        total++; if (strikes !== 2'd2 || beep !== 1'b0) begin bad++; $display("FAIL defuse_strikes got=%0d/%0b exp=2/0", strikes, beep); end
        module_done = 1'b0;
        wrong_tgl = ~wrong_tgl;
        step(1200);
        total++; if (tm !== {4'd4, 3'd5, 4'd8} || strikes !== 2'd2 || state !== 2'd2) begin
            bad++; $display("FAIL defuse_frozen got=%0h/%0d/%0d exp=458/2/2", tm, strikes, state);
        end
    endtask

    task automatic test_restart_from_defuse;
        start_btn = 1'b1;
        step(3);
        total++; if (state !== 2'd0 || tm !== {4'd5, 3'd0, 4'd0} || strikes !== 2'd0) begin
            bad++; $display("FAIL defuse_rearm got=%0d/%0h/%0d exp=0/500/0", state, tm, strikes);
        end
        start_btn = 1'b0;
        step(4);
        start_btn = 1'b1;
        step(3);
        total++; if (state !== 2'd1 || oseed !== lfsr_prev[11:0] || mod !== lfsr_prev[12]) begin
            bad++; $display("FAIL game3_seed got=%0d/%0h/%0b exp=1/%0h/%0b", state, oseed, mod, lfsr_prev[11:0], lfsr_prev[12]);
        end
        total++; if (oseed === seed_prev) begin bad++; $display("FAIL game3_new_seed got=%0h exp!=%0h", oseed, seed_prev); end
        start_btn = 1'b0;
    endtask

    task automatic test_timeout;
        start2 = 1'b1;
        step(3);
        total++; if (state2 !== 2'd1) begin bad++; $display("FAIL to_arm got=%0d exp=1", state2); end
        start2 = 1'b0;
        step(999);
        total++; if (tm2 !== {4'd0, 3'd0, 4'd2}) begin bad++; $display("FAIL to_pre got=%0h exp=2", tm2); end
        step(1);
        total++; if (tm2 !== {4'd0, 3'd0, 4'd1} || state2 !== 2'd1) begin bad++; $display("FAIL to_one got=%0h/%0d exp=1/1", tm2, state2); end
        step(999);
        total++; if (tm2 !== {4'd0, 3'd0, 4'd1} || state2 !== 2'd1) begin bad++; $display("FAIL to_hold got=%0h/%0d exp=1/1", tm2, state2); end
        step(1);
        total++; if (tm2 !== 11'd0 || state2 !== 2'd3 || beep2 !== 1'b1) begin
            bad++; $display("FAIL to_explode got=%0h/%0d/%0b exp=0/3/1", tm2, state2, beep2);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_start_and_tick();
        test_strikes();
        test_restart_from_explode();
        test_speedup();
        test_defuse_same_cycle();
        test_restart_from_defuse();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Bomb-level game controller for the Keep Talking board. It sits on both sides of the colour-sequence puzzle module. Upstream, it supplies the puzzle seed, the variant bit and the strike count. Downstream, it consumes the puzzle's strike toggle and its done level, and from those it runs the countdown timer, strike accounting and the armed/defused/exploded state machine.

## Interface
Parameters:
- TICKS_PER_SEC, 1000: Clk cycles per game second.
- START_SEC, 300: initial countdown in seconds; legal range 1..599.
- MAX_STRIKES, 3: strike count that detonates.
- BEEP_MS, 100: beep pulse length, in Clk cycles.

Ports:
- Clk  in  1  system clock, 1 kHz.
- Rst_n  in  1  reset, asynchronous, active-low.
- start_btn  in  1  debounced start/re-arm button, asynchronous.
- wrong_tgl  in  1  strike toggle from the puzzle; every change is one strike; asynchronous.
- module_done  in  1  puzzle solved, level.
- oseed  out  12  puzzle seed (six 2-bit colour indices).
- mod  out  1  puzzle variant select.
- wrong_time  out  2  strikes so far, saturated at 2; feeds the puzzle's answer table.
- strikes  out  2  raw strike count, 0..MAX_STRIKES.
- time_min  out  4  BCD minutes.
- time_sec_t  out  3  BCD tens of seconds.
- time_sec_u  out  4  BCD units of seconds.
- state  out  2  IDLE=0, ARMED=1, DEFUSED=2, EXPLODED=3.
- beep  out  1  buzzer enable.

## Operation
- Input conditioning:
  - start_btn and wrong_tgl each pass through a 2-flop synchroniser plus one history flop.
  - Start event: rising edge of start_btn.
  - Strike event: any change of wrong_tgl.
- LFSR:
  - 16-bit Fibonacci, taps 16/14/13/11, reset value 16'hACE1.
  - Steps every cycle in every state.
- IDLE:
  - Timer held at START_SEC; strikes = 0; beep = 0.
  - Strike events are ignored.
  - Start event: latch oseed = lfsr[11:0] and mod = lfsr[12]; clear the prescaler; go to ARMED.
- ARMED:
  - Prescaler counts 0..period-1. Terminal count is a second tick, which decrements the BCD mm:ss with borrow chain 0:00 <- 0:01, x:00 -> (x-1):59.
  - Strike event: strikes+1.
  - Transitions, evaluated in one cycle with priority DEFUSED > strike detonation > timeout:
    - module_done = 1 -> DEFUSED.
    - strikes+1 == MAX_STRIKES -> EXPLODED.
    - tick while time = 0:01 -> time 0:00 and EXPLODED.
- DEFUSED / EXPLODED:
  - Timer, strikes, oseed and mod are frozen; strike events are ignored.
  - Start event -> IDLE (timer reloaded, strikes cleared).
- wrong_time = (strikes ≥ 2) ? 2 : strikes. It never presents 3.
- beep:
  - ARMED: high for BEEP_MS cycles starting at each tick.
  - EXPLODED: constantly high.
  - IDLE and DEFUSED: low.
- Reset values:
  - state = IDLE; strikes = 0; wrong_time = 0; beep = 0.
  - oseed = 0; mod = 0; prescaler = 0.
  - Timer = START_SEC in BCD (default 5:00).
- Reset mid-game returns to IDLE immediately; there is no memory of the previous game.

## Timing
- Start and strike events act on the 3rd rising Clk edge after the input changes (2 sync + 1 edge-detect register).
- Two wrong_tgl changes closer than 2 cycles may merge. The puzzle's debounce spacing guarantees this does not happen in use.
- module_done is used unsynchronised; it comes from the same Clk domain.
- First tick: TICKS_PER_SEC cycles after ARMED entry. Later ticks every period cycles.
- All outputs are registered. state, time and strikes update on the same edge as the causing event.
- The beep pulse starts on the tick edge.

## Configuration
- GAME_CTRL_SPEEDUP_EN defined: the prescaler period depends on strikes.
  - 0 strikes -> TICKS_PER_SEC.
  - 1 strike -> 3/4·TICKS_PER_SEC.
  - 2 or more -> 1/2·TICKS_PER_SEC.
  - The new period applies from the next prescaler wrap; the current count is not truncated.
- Undefined: period is TICKS_PER_SEC at all times.

## Structure
- Package game_pkg: state enum, LFSR taps and reset constant, default START_SEC.
- Sub-module bcd_timer (load, dec, BCD mm:ss out, zero flag). Everything else stays inline.

## Test plan
- Reset, then start_btn pulse -> ARMED on 3rd edge; oseed/mod equal lfsr[11:0]/[12] at the latch edge; first tick after 1000 cycles shows 4:59.
- Three wrong_tgl changes spaced 300 cycles apart in ARMED -> wrong_time 1, 2, 2; strikes 1, 2, 3; EXPLODED on the third; beep stuck at 1.
- START_SEC=2 with no input -> 0:01 at cycle 1000; 0:00 and EXPLODED at cycle 2000.
- module_done and the third strike land on the same cycle -> DEFUSED; strikes stay 2.
- DEFUSED, then start_btn -> IDLE with timer 5:00 and strikes 0; a second start arms with a new oseed.
- With GAME_CTRL_SPEEDUP_EN after 2 strikes -> consecutive ticks 500 cycles apart; without the macro -> 1000.
